// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 size/sign encodings
//   - lsu_state_e FSM states
//   - lsu_op_t latched operation descriptor
//   - size_mask / size_lowbits / f3_legal helpers
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  typedef struct packed {
    logic       wen;
    logic [2:0] funct3;
  } lsu_op_t;

  // Byte-enable pattern for an access of this size, lane 0.
  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_lowbits(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // 111 never exists; d and wu only exist on a 64-bit datapath.
  function automatic logic f3_legal(input logic [2:0] f3, input int xlen);
    if (f3 == 3'b111) return 1'b0;
    if (xlen == 32 && (f3 == F3_D || f3 == F3_WU)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: EXU op handshake, WBU result handshake and data-memory bus.
//   master modport: the LSU side.  slave modport: EXU/WBU/memory side.
interface lsu_bus_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NUM_LANES = XLEN / 8;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_wen;
  logic [2:0]           in_funct3;
  logic [ADDR_W-1:0]    in_addr;
  logic [XLEN-1:0]      in_wdata;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_rdata;
  logic                 out_err;

  logic                 bus_req_valid;
  logic                 bus_req_ready;
  logic                 bus_req_wen;
  logic [ADDR_W-1:0]    bus_req_addr;
  logic [XLEN-1:0]      bus_req_wdata;
  logic [NUM_LANES-1:0] bus_req_wstrb;
  logic                 bus_rsp_valid;
  logic [XLEN-1:0]      bus_rsp_rdata;
  logic                 bus_rsp_err;

  modport master (
    input  in_valid, in_wen, in_funct3, in_addr, in_wdata,
    output in_ready,
    output out_valid, out_rdata, out_err,
    input  out_ready,
    output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready,
    input  bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    output in_valid, in_wen, in_funct3, in_addr, in_wdata,
    input  in_ready,
    input  out_valid, out_rdata, out_err,
    output out_ready,
    input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready,
    output bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering.
//   funct3, lane     : access size/sign and byte offset within the bus word
//   st_data          : LSB-aligned store data -> st_lanes / st_strb on bus lanes
//   ld_raw           : raw bus read word      -> ld_data shifted and extended
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN      = 32,
  localparam int NUM_LANES = XLEN / 8,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [2:0]           funct3,
  input  logic [LANE_W-1:0]    lane,
  input  logic [XLEN-1:0]      st_data,
  output logic [XLEN-1:0]      st_lanes,
  output logic [NUM_LANES-1:0] st_strb,
  input  logic [XLEN-1:0]      ld_raw,
  output logic [XLEN-1:0]      ld_data
);

  logic [LANE_W+2:0] sh_amt;
  logic [XLEN-1:0]   ld_sh;

  assign sh_amt   = {lane, 3'b000};
  assign st_lanes = st_data << sh_amt;
  assign st_strb  = NUM_LANES'(size_mask(funct3)) << lane;
  assign ld_sh    = ld_raw >> sh_amt;

  always_comb begin
    ld_data = ld_sh;
    case (funct3)
      F3_B:    ld_data = XLEN'($signed(ld_sh[7:0]));
      F3_H:    ld_data = XLEN'($signed(ld_sh[15:0]));
      F3_W:    ld_data = XLEN'($signed(ld_sh[31:0]));
      F3_BU:   ld_data = XLEN'(ld_sh[7:0]);
      F3_HU:   ld_data = XLEN'(ld_sh[15:0]);
      F3_WU:   ld_data = XLEN'(ld_sh[31:0]);
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: multi-cycle load/store unit, EXU -> data-memory bus -> WBU.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : lsu_bus_if.master (EXU op in, WBU result out, req/rsp bus)
// One op in flight: IDLE accepts, REQ presents the request, WAIT holds for
// the response (or timeout), DONE presents the result until taken.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of
// being silently aligned down.
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_bus_if.master bus
);

  localparam int NUM_LANES = XLEN / 8;
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [TMR_W-1:0]  timer_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0]    low_bits, eff_addr;
  logic                 fault_now, tmo;
  logic [XLEN-1:0]      st_lanes, ld_data;
  logic [NUM_LANES-1:0] st_strb;
  logic                 in_req;

  // Accept-time decode: natural alignment and funct3 legality.
  assign low_bits = ADDR_W'(size_lowbits(bus.in_funct3));
  assign eff_addr = bus.in_addr & ~low_bits;
`ifdef LSU_MISALIGN_TRAP_EN
  assign fault_now = !f3_legal(bus.in_funct3, XLEN) || (|(bus.in_addr & low_bits));
`else
  assign fault_now = !f3_legal(bus.in_funct3, XLEN);
`endif

  assign tmo = (TIMEOUT != 0) && (timer_q == TMR_LAST);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (op_q.funct3),
    .lane     (addr_q[LANE_W-1:0]),
    .st_data  (wdata_q),
    .st_lanes (st_lanes),
    .st_strb  (st_strb),
    .ld_raw   (bus.bus_rsp_rdata),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid)      state_d = fault_now ? DONE : REQ;
      REQ:  if (bus.bus_req_ready) state_d = WAIT;
      WAIT: if (bus.bus_rsp_valid || tmo) state_d = DONE;
      DONE: if (bus.out_ready)     state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Request fields come straight from latched op state, so they cannot move
  // while the bus stalls; outside REQ everything is driven to zero.
  assign in_req            = (state_q == REQ);
  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_rdata     = rdata_q;
  assign bus.out_err       = err_q;
  assign bus.bus_req_valid = in_req;
  assign bus.bus_req_wen   = in_req & op_q.wen;
  assign bus.bus_req_addr  = in_req ? {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign bus.bus_req_wdata = (in_req && op_q.wen) ? st_lanes : '0;
  assign bus.bus_req_wstrb = !in_req ? '0 : (op_q.wen ? st_strb : '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          op_q    <= '{wen: bus.in_wen, funct3: bus.in_funct3};
          addr_q  <= eff_addr;
          wdata_q <= bus.in_wdata;
          timer_q <= '0;
          rdata_q <= '0;
          err_q   <= fault_now;
        end
        // Response beats a simultaneous timeout expiry.
        WAIT: if (bus.bus_rsp_valid) begin
          rdata_q <= op_q.wen ? '0 : ld_data;
          err_q   <= bus.bus_rsp_err;
        end else if (tmo) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
        DONE: if (bus.out_ready) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: directed vectors for lsu_bus, XLEN=32, TIMEOUT=8.
module tb_lsu_bus;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_bus_if #(.XLEN(32), .ADDR_W(32)) bus ();

  lsu_bus #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Observations from the last run_op.
  logic        o_req, o_stable, o_hold, o_valid, o_err, o_idle, o_wen;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_wstrb;
  int          o_lat, o_wcyc;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op and play the bus: ready after rdy_dly stalled REQ cycles,
  // response on WAIT cycle rsp_dly (-1 = never), out_ready after ordy_dly.
  task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rsp_d, input logic rsp_e, input int ordy_dly);
    int stall, wcnt;
    logic in_wait, hs;
    bus.in_valid = 1'b1; bus.in_wen = wen; bus.in_funct3 = f3;
    bus.in_addr = addr; bus.in_wdata = wd;
    tick();
    bus.in_valid = 1'b0; bus.in_addr = '1; bus.in_wdata = '1; bus.in_funct3 = 3'b111;
    o_lat = 1; o_req = 0; o_stable = 1; o_hold = 1;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_wen = 0;
    stall = 0; wcnt = 0; in_wait = 0;
    for (int c = 0; c < 100 && !bus.out_valid; c++) begin
      bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0;
      if (bus.bus_req_valid) begin
        if (!o_req) begin
          o_req = 1; o_addr = bus.bus_req_addr; o_wdata = bus.bus_req_wdata;
          o_wstrb = bus.bus_req_wstrb; o_wen = bus.bus_req_wen;
        end else if (bus.bus_req_addr !== o_addr || bus.bus_req_wdata !== o_wdata ||
                     bus.bus_req_wstrb !== o_wstrb || bus.bus_req_wen !== o_wen) o_stable = 0;
        if (bus.in_ready) o_stable = 0;
        bus.bus_req_ready = (stall >= rdy_dly);
        stall++;
      end
      if (in_wait && wcnt == rsp_dly) begin
        bus.bus_rsp_valid = 1'b1; bus.bus_rsp_rdata = rsp_d; bus.bus_rsp_err = rsp_e;
      end
      hs = bus.bus_req_valid && bus.bus_req_ready;
      tick();
      o_lat++;
      if (in_wait) wcnt++;
      if (hs) in_wait = 1;
    end
    bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0; bus.bus_rsp_err = 1'b0;
    o_wcyc = wcnt;
    o_valid = bus.out_valid; o_rdata = bus.out_rdata; o_err = bus.out_err;
    for (int k = 0; k < ordy_dly; k++) begin
      bus.out_ready = 1'b0;
      tick();
      if (!bus.out_valid || bus.out_rdata !== o_rdata || bus.out_err !== o_err) o_hold = 0;
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    o_idle = bus.in_ready && !bus.out_valid;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.in_wen = 0; bus.in_funct3 = 0; bus.in_addr = 0; bus.in_wdata = 0;
    bus.out_ready = 0; bus.bus_req_ready = 0; bus.bus_rsp_valid = 0;
    bus.bus_rsp_rdata = 0; bus.bus_rsp_err = 0;
    tick(); tick();
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_rdata", bus.out_rdata, 0);
    chk("rst_out_err",   bus.out_err, 0);
    chk("rst_req_valid", bus.bus_req_valid, 0);
    chk("rst_req_fields", {bus.bus_req_wen, bus.bus_req_addr, bus.bus_req_wdata, bus.bus_req_wstrb}, 0);
    rst = 1'b0;
    tick();

    // lw, immediate ready and response
    run_op(0, F3_W, 32'h8000_0004, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    chk("lw_req_addr", o_addr, 32'h8000_0004);
    chk("lw_wstrb", o_wstrb, 4'hF);
    chk("lw_wen", o_wen, 0);
    chk("lw_rdata", o_rdata, 32'hDEAD_BEEF);
    chk("lw_err", o_err, 0);
    chk("lw_latency", o_lat, 3);
    chk("lw_idle", o_idle, 1);

    run_op(0, F3_B, 32'h8000_0003, 0, 0, 0, 32'h80FF_FFFF, 0, 0);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb_req_addr", o_addr, 32'h8000_0000);
    run_op(0, F3_BU, 32'h8000_0003, 0, 0, 0, 32'h80FF_FFFF, 0, 0);
    chk("lbu_rdata", o_rdata, 32'h0000_0080);
    run_op(0, F3_HU, 32'h8000_0002, 0, 0, 0, 32'h8001_0000, 0, 0);
    chk("lhu_rdata", o_rdata, 32'h0000_8001);
    run_op(0, F3_H, 32'h8000_0002, 0, 0, 0, 32'h8001_0000, 0, 0);
    chk("lh_rdata", o_rdata, 32'hFFFF_8001);

    // stores
    run_op(1, F3_H, 32'h8000_0102, 32'h1234_ABCD, 0, 0, 32'hFFFF_FFFF, 0, 0);
    chk("sh_wdata", o_wdata, 32'hABCD_0000);
    chk("sh_wstrb", o_wstrb, 4'b1100);
    chk("sh_wen", o_wen, 1);
    chk("sh_req_addr", o_addr, 32'h8000_0100);
    chk("sh_rdata", o_rdata, 0);
    run_op(1, F3_B, 32'h8000_0001, 32'h0000_00A5, 0, 0, 0, 0, 0);
    chk("sb_wdata", o_wdata, 32'h0000_A500);
    chk("sb_wstrb", o_wstrb, 4'b0010);

    // stalled request and held result
    run_op(1, F3_W, 32'h8000_0010, 32'h0102_0304, 5, 0, 32'hFFFF_FFFF, 0, 3);
    chk("stall_stable", o_stable, 1);
    chk("stall_latency", o_lat, 8);
    chk("stall_wdata", o_wdata, 32'h0102_0304);
    chk("hold_result", o_hold, 1);
    chk("hold_rdata", o_rdata, 0);
    chk("hold_idle", o_idle, 1);

    // bus error
    run_op(0, F3_W, 32'h8000_0020, 0, 0, 1, 32'h1111_1111, 1, 0);
    chk("buserr_err", o_err, 1);

    // timeout, then response on the last WAIT cycle
    run_op(0, F3_W, 32'h8000_0030, 0, 0, -1, 0, 0, 0);
    chk("tmo_valid", o_valid, 1);
    chk("tmo_err", o_err, 1);
    chk("tmo_wait_cycles", o_wcyc, 8);
    chk("tmo_rdata", o_rdata, 0);
    run_op(0, F3_W, 32'h8000_0030, 0, 0, 7, 32'h1122_3344, 0, 0);
    chk("lastcyc_rdata", o_rdata, 32'h1122_3344);
    chk("lastcyc_err", o_err, 0);
    chk("lastcyc_wait_cycles", o_wcyc, 8);

    // illegal funct3 on XLEN=32
    run_op(0, F3_D, 32'h8000_0040, 0, 0, 0, 32'h5555_5555, 0, 0);
    chk("ld_illegal_err", o_err, 1);
    chk("ld_illegal_noreq", o_req, 0);
    chk("ld_illegal_lat", o_lat, 1);
    run_op(1, 3'b111, 32'h8000_0040, 0, 0, 0, 0, 0, 0);
    chk("f3_111_err", o_err, 1);
    chk("f3_111_noreq", o_req, 0);

    // misaligned word
    run_op(0, F3_W, 32'h8000_0002, 0, 0, 0, 32'hCAFE_F00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", o_err, 1);
    chk("mis_noreq", o_req, 0);
    chk("mis_lat", o_lat, 1);
`else
    chk("mis_req_addr", o_addr, 32'h8000_0000);
    chk("mis_err", o_err, 0);
    chk("mis_rdata", o_rdata, 32'hCAFE_F00D);
`endif

    // response while idle is ignored
    bus.bus_rsp_valid = 1; bus.bus_rsp_rdata = 32'h7777_7777;
    tick();
    bus.bus_rsp_valid = 0;
    chk("idle_rsp_ignored", bus.out_valid, 0);
    chk("idle_rsp_ready", bus.in_ready, 1);

    // reset while waiting for a response
    bus.in_valid = 1; bus.in_wen = 0; bus.in_funct3 = F3_W; bus.in_addr = 32'h8000_0050;
    tick();
    bus.in_valid = 0; bus.bus_req_ready = 1;
    tick();
    bus.bus_req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_req_valid", bus.bus_req_valid, 0);
    bus.bus_rsp_valid = 1; bus.bus_rsp_rdata = 32'h9999_9999;
    tick();
    bus.bus_rsp_valid = 0;
    chk("midrst_rsp_dropped", bus.out_valid, 0);
    chk("midrst_rdata", bus.out_rdata, 0);

    // normal op after reset
    run_op(0, F3_BU, 32'h8000_0061, 0, 0, 0, 32'h0000_C300, 0, 0);
    chk("post_rst_rdata", o_rdata, 32'h0000_00C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
